// File: rtl/muldiv_if.sv
// muldiv_if: request/response bundle between the EX stage and the
// iterative multiply/divide unit. The pipeline side is the master; the
// execution unit is the slave.
interface muldiv_if #(
  parameter int XLEN = 32
);
  logic            Start;
  logic [2:0]      Funct3;
  logic [XLEN-1:0] SrcA;
  logic [XLEN-1:0] SrcB;
  logic            Kill;
  logic            Busy;
  logic            Done;
  logic [XLEN-1:0] Result;

  modport master (
    output Start, Funct3, SrcA, SrcB, Kill,
    input  Busy, Done, Result
  );

  modport slave (
    input  Start, Funct3, SrcA, SrcB, Kill,
    output Busy, Done, Result
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit sitting beside the ALU.
// A shift-add multiplier and a restoring divider share the accumulator and
// operand registers, retiring one bit per cycle. Signs are stripped at
// accept and reapplied in a single FIX cycle.
// Optional build macro MULDIV_EARLY_OUT_EN: multiplies finish as soon as the
// remaining multiplier magnitude is zero instead of always running XLEN steps.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input logic     clk,
  input logic     reset,
  muldiv_if.slave bus
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic              rem_neg_q, rem_neg_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [2*XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0]   mplier_q, mplier_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              signed_a, signed_b, a_neg, b_neg, div_ovf;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     div_part, div_diff;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  // Operand interpretation at accept: which sources are signed, their
  // magnitudes, and the one signed-divide overflow pattern.
  assign signed_a = bus.Funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b110};
  assign signed_b = bus.Funct3 inside {3'b000, 3'b001, 3'b100, 3'b110};
  assign a_neg    = signed_a & bus.SrcA[XLEN-1];
  assign b_neg    = signed_b & bus.SrcB[XLEN-1];
  assign mag_a    = a_neg ? -bus.SrcA : bus.SrcA;
  assign mag_b    = b_neg ? -bus.SrcB : bus.SrcB;
  assign div_ovf  = (bus.Funct3 == 3'b100 || bus.Funct3 == 3'b110) &&
                    (bus.SrcA == MIN_VAL) && (bus.SrcB == '1);

  // Restoring divide step: shift the next dividend bit into the partial
  // remainder and trial-subtract the divisor.
  assign div_part = acc_q[2*XLEN-1:XLEN-1];
  assign div_diff = div_part - {1'b0, mcand_q[XLEN-1:0]};

  // Sign restoration applied during FIX.
  assign prod_fix = neg_q ? -acc_q : acc_q;
  assign quo_fix  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign rem_fix  = rem_neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

  // Next-state and datapath sequencing for all five states.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    result_d  = result_q;
    case (state_q)
      S_IDLE: begin
        if (bus.Start && !bus.Kill) begin
          op_d      = bus.Funct3;
          cnt_d     = CW'(XLEN);
          neg_d     = a_neg ^ b_neg;
          rem_neg_d = a_neg;
          if (!bus.Funct3[2]) begin
            acc_d    = '0;
            mcand_d  = {{XLEN{1'b0}}, mag_a};
            mplier_d = mag_b;
            state_d  = S_MUL;
`ifdef MULDIV_EARLY_OUT_EN
            if (mag_b == '0) state_d = S_FIX;
`endif
          end else begin
            acc_d    = {{XLEN{1'b0}}, mag_a};
            mcand_d  = {{XLEN{1'b0}}, mag_b};
            mplier_d = '0;
            state_d  = S_DIV;
            if (bus.SrcB == '0) begin
              result_d = bus.Funct3[1] ? bus.SrcA : '1;
              state_d  = S_DONE;
            end else if (div_ovf) begin
              result_d = bus.Funct3[1] ? '0 : MIN_VAL;
              state_d  = S_DONE;
            end
          end
        end
      end
      S_MUL: begin
        if (bus.Kill) begin
          state_d = S_IDLE;
        end else begin
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = S_FIX;
`ifdef MULDIV_EARLY_OUT_EN
          if (mplier_d == '0) state_d = S_FIX;
`endif
        end
      end
      S_DIV: begin
        if (bus.Kill) begin
          state_d = S_IDLE;
        end else begin
          if (!div_diff[XLEN]) begin
            acc_d = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
          end else begin
            acc_d = {div_part[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
          end
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (bus.Kill) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
          case (op_q)
            3'b000:                 result_d = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: result_d = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         result_d = quo_fix;
            default:                result_d = rem_fix;
          endcase
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      result_q  <= result_d;
    end
  end

  assign bus.Busy   = (state_q != S_IDLE);
  assign bus.Done   = (state_q == S_DONE);
  assign bus.Result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: self-checking bench for muldiv_unit. Directed vectors from
// a table, random ops against an arithmetic reference model, and hand-built
// sequences for kill, reset and held-Start corner cases.
module tb_muldiv_unit;

  localparam int XLEN = 32;
  localparam logic [31:0] MIN_VAL = 32'h8000_0000;

  typedef struct packed {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  muldiv_if #(.XLEN(XLEN)) bus();

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference result computed with wide plain arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
    longint      sa, sb, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'h0, b});
    case (f)
      3'b000: begin p = 64'(sa * sb); return p[31:0]; end
      3'b001: begin p = 64'(sa * sb); return p[63:32]; end
      3'b010: begin p = 64'(sa * ub); return p[63:32]; end
      3'b011: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
      3'b100: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        if (a == MIN_VAL && b == 32'hFFFF_FFFF) return MIN_VAL;
        return 32'(sa / sb);
      end
      3'b101: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'b110: begin
        if (b == 32'h0) return a;
        if (a == MIN_VAL && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(sa % sb);
      end
      default: begin
        if (b == 32'h0) return a;
        return a % b;
      end
    endcase
  endfunction

  // Expected number of cycles from the accept edge to the Done cycle.
  function automatic int exp_latency(input logic [2:0] f, input logic [31:0] a,
                                     input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    logic [31:0] m;
    int          n;
`endif
    if (f[2]) begin
      if (b == 32'h0) return 1;
      if ((f == 3'b100 || f == 3'b110) && a == MIN_VAL && b == 32'hFFFF_FFFF) return 1;
      return XLEN + 2;
    end
`ifdef MULDIV_EARLY_OUT_EN
    m = b;
    n = 0;
    if ((f == 3'b000 || f == 3'b001) && b[31]) m = -b;
    for (int i = 0; i < XLEN; i++) if (m[i]) n = i + 1;
    return n + 2;
`else
    return XLEN + 2;
`endif
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return MIN_VAL;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Issue one op in the current cycle and follow it until the cycle after Done.
  task automatic apply_stimulus(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] res, output int lat,
                                output logic busy_ok, output logic idle_ok);
    bus.Start  = 1'b1;
    bus.Funct3 = f;
    bus.SrcA   = a;
    bus.SrcB   = b;
    @(posedge clk); #1;
    bus.Start = 1'b0;
    lat     = 1;
    busy_ok = 1'b1;
    while (!bus.Done && lat < 200) begin
      if (!bus.Busy) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    res = bus.Result;
    if (!bus.Busy) busy_ok = 1'b0;
    @(posedge clk); #1;
    idle_ok = !bus.Busy && !bus.Done;
  endtask

  task automatic run_vector(input string name, input logic [2:0] f, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp);
    logic [31:0] res;
    int          lat;
    logic        busy_ok, idle_ok;
    apply_stimulus(f, a, b, res, lat, busy_ok, idle_ok);
    check_output({name, "_result"}, res, exp);
    check_output({name, "_latency"}, 32'(lat), 32'(exp_latency(f, a, b)));
    check_output({name, "_busy_held"}, {31'b0, busy_ok}, 32'd1);
    check_output({name, "_busy_drop"}, {31'b0, idle_ok}, 32'd1);
  endtask

  // Main test sequence.
  initial begin
    vec_t        vecs[15];
    logic [2:0]  f;
    logic [31:0] a, b, res;
    int          lat, done_count;

    vecs[0]  = '{3'b000, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB};
    vecs[1]  = '{3'b001, MIN_VAL,       MIN_VAL,       32'h4000_0000};
    vecs[2]  = '{3'b011, MIN_VAL,       MIN_VAL,       32'h4000_0000};
    vecs[3]  = '{3'b010, MIN_VAL,       MIN_VAL,       32'hC000_0000};
    vecs[4]  = '{3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD};
    vecs[5]  = '{3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF};
    vecs[6]  = '{3'b101, 32'd100,       32'd7,         32'd14};
    vecs[7]  = '{3'b111, 32'd100,       32'd7,         32'd2};
    vecs[8]  = '{3'b101, 32'h1234,      32'd0,         32'hFFFF_FFFF};
    vecs[9]  = '{3'b111, 32'h1234,      32'd0,         32'h1234};
    vecs[10] = '{3'b100, MIN_VAL,       32'hFFFF_FFFF, MIN_VAL};
    vecs[11] = '{3'b110, MIN_VAL,       32'hFFFF_FFFF, 32'h0};
    vecs[12] = '{3'b011, 32'd5,         32'd3,         32'h0};
    vecs[13] = '{3'b000, 32'd5,         32'd3,         32'd15};
    vecs[14] = '{3'b000, 32'h1234_5678, 32'd0,         32'h0};

    bus.Start  = 1'b0;
    bus.Kill   = 1'b0;
    bus.Funct3 = 3'b000;
    bus.SrcA   = '0;
    bus.SrcB   = '0;
    reset      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_busy", {31'b0, bus.Busy}, 32'd0);
    check_output("reset_done", {31'b0, bus.Done}, 32'd0);
    check_output("reset_result", bus.Result, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++)
      run_vector($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp);

    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7));
      a = pick_operand();
      b = pick_operand();
      run_vector($sformatf("rand%0d_f%0d", i, f), f, a, b, ref_result(f, a, b));
    end

    // Kill during DIV at T+10: unit idles at T+11 with the old Result kept.
    run_vector("pre_kill", 3'b101, 32'd100, 32'd7, 32'd14);
    bus.Start  = 1'b1;
    bus.Funct3 = 3'b100;
    bus.SrcA   = 32'hFFFF_FFF9;
    bus.SrcB   = 32'd2;
    @(posedge clk); #1;
    bus.Start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    bus.Kill = 1'b1;
    @(posedge clk); #1;
    bus.Kill = 1'b0;
    check_output("kill_busy", {31'b0, bus.Busy}, 32'd0);
    check_output("kill_done", {31'b0, bus.Done}, 32'd0);
    check_output("kill_result_held", bus.Result, 32'd14);
    run_vector("post_kill", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);

    // Kill together with Start in IDLE: nothing is accepted.
    bus.Start  = 1'b1;
    bus.Kill   = 1'b1;
    bus.Funct3 = 3'b101;
    bus.SrcA   = 32'd9;
    bus.SrcB   = 32'd0;
    @(posedge clk); #1;
    bus.Start = 1'b0;
    bus.Kill  = 1'b0;
    check_output("kill_start_busy", {31'b0, bus.Busy}, 32'd0);
    @(posedge clk); #1;
    check_output("kill_start_done", {31'b0, bus.Done}, 32'd0);

    // Kill while in DONE: the Done pulse still appears.
    bus.Start  = 1'b1;
    bus.Funct3 = 3'b101;
    bus.SrcA   = 32'h1234;
    bus.SrcB   = 32'd0;
    @(posedge clk); #1;
    bus.Start = 1'b0;
    bus.Kill  = 1'b1;
    check_output("kill_in_done_pulse", {31'b0, bus.Done}, 32'd1);
    check_output("kill_in_done_result", bus.Result, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    bus.Kill = 1'b0;
    check_output("kill_in_done_idle", {31'b0, bus.Busy}, 32'd0);

    // Start held high while busy: exactly one Done for the one accept.
    bus.Start  = 1'b1;
    bus.Funct3 = 3'b000;
    bus.SrcA   = 32'd7;
    bus.SrcB   = 32'hFFFF_FFFD;
    @(posedge clk); #1;
    lat = 1;
    while (!bus.Done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    bus.Start = 1'b0;
    check_output("held_start_latency", 32'(lat), 32'(exp_latency(3'b000, 32'd7, 32'hFFFF_FFFD)));
    check_output("held_start_result", bus.Result, 32'hFFFF_FFEB);
    done_count = bus.Done ? 1 : 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.Done) done_count++;
    end
    check_output("held_start_done_count", 32'(done_count), 32'd1);

    // Asynchronous reset mid-operation clears outputs immediately.
    bus.Start  = 1'b1;
    bus.Funct3 = 3'b001;
    bus.SrcA   = 32'h0123_4567;
    bus.SrcB   = 32'h89AB_CDEF;
    @(posedge clk); #1;
    bus.Start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    reset = 1'b0;
    #1;
    check_output("midreset_busy", {31'b0, bus.Busy}, 32'd0);
    check_output("midreset_done", {31'b0, bus.Done}, 32'd0);
    check_output("midreset_result", bus.Result, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.Done) done_count++;
    end
    check_output("midreset_no_done", 32'(done_count), 32'd1);
    run_vector("post_reset", 3'b111, 32'hFFFF_FFF9, 32'd2, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit for R-type ops with Funct7=0000001; these ops bypass the single-cycle ALU.
- Sits beside the ALU in EX. Accepts one op via a Start pulse, holds Busy so the hazard unit stalls the pipeline, then returns Result with a one-cycle Done pulse.
- Internally sequences a shift-add multiplier and a restoring divider over shared registers, at one bit per cycle.

Parameters:
- XLEN, 32, operand/result width; must be a power of 2 ≥ 8.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- Start  in  1  op request; sampled only in IDLE.
- Funct3  in  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- SrcA  in  XLEN  rs1 operand (multiplicand/dividend).
- SrcB  in  XLEN  rs2 operand (multiplier/divisor).
- Kill  in  1  pipeline flush; aborts any op in flight.
- Busy  out  1  high while an accepted op is incomplete.
- Done  out  1  one-cycle pulse; Result valid.
- Result  out  XLEN  selected result; held until the next accepted Start or reset.

Behaviour:
- Reset (reset=0, async): state=IDLE; Busy=0, Done=0, Result=0; counter and data registers cleared. Reset mid-operation discards the op with no Done.
- States: IDLE, MUL, DIV, FIX, DONE.
- Accept (cycle T): IDLE and Start=1 and Kill=0.
  - Latch Funct3.
  - Latch operand magnitudes and result sign:
    - MUL, MULH, DIV, REM: both operands signed.
    - MULHSU: SrcA signed, SrcB unsigned.
    - MULHU, DIVU, REMU: both unsigned.
  - Load counter with XLEN. Next state is MUL (Funct3[2]=0) or DIV (Funct3[2]=1).
- DIV special cases, detected at accept; next state is DONE directly, so Done is at T+1:
  - Divisor=0: quotient = all ones; remainder = SrcA.
  - Signed DIV/REM with SrcA = most negative value and SrcB = −1: quotient = most negative value; remainder = 0.
- MUL: each cycle, add the multiplicand into the 2×XLEN product if multiplier LSB=1, then shift. Decrement counter; at counter=1, go to FIX.
- DIV: restoring divide, one quotient bit per cycle. Decrement counter; at counter=1, go to FIX.
- FIX (1 cycle): apply sign.
  - Product: two's-complement negate the 2×XLEN value if the result sign is negative.
  - Quotient: negative if operand signs differ.
  - Remainder: takes the dividend's sign.
  - Result select: MUL = product low half; MULH/MULHSU/MULHU = product high half; DIV/DIVU = quotient; REM/REMU = remainder.
- DONE (1 cycle): Done=1, Busy=1. Next state IDLE.
- Latency for normal ops: Busy=1 during T+1..T+XLEN+2; Done at T+XLEN+2 (T+34 for XLEN=32). Busy drops at T+XLEN+3.
- Start while Busy=1 is ignored; no queueing.
- Kill=1 in any non-IDLE state: next state IDLE, Busy=0 next cycle, no Done, Result unchanged.
- Kill=1 together with Start in IDLE: Kill wins; the op is not accepted.
- Kill in DONE: the Done pulse in that cycle still occurs.
- Back-to-back: a Start in the first IDLE cycle after DONE is accepted normally.
- All arithmetic is modulo 2^XLEN per half; no exceptions or flags.

Optional Feature:
- MULDIV_EARLY_OUT_EN defined: in MUL, if the remaining (shifted) multiplier register is zero after an iteration, go to FIX immediately. The product is zero-extended appropriately before FIX. Latency = number of significant multiplier-magnitude bits + 2 cycles; minimum Done at T+2 when the multiplier is 0. DIV timing is unchanged.
- Undefined: MUL always runs XLEN iterations, giving fixed latency.

Test Plan:
- MUL SrcA=7, SrcB=0xFFFFFFFD (−3), Start at T -> Busy T+1..T+34; Done at T+34 with Result=0xFFFFFFEB; Busy=0 at T+35.
- MULH SrcA=SrcB=0x80000000 -> Result=0x40000000. Same operands with MULHU -> Result=0x40000000; MULHSU -> 0xC0000000.
- DIV SrcA=0xFFFFFFF9 (−7), SrcB=2 -> Result=0xFFFFFFFD. Same operands with REM -> 0xFFFFFFFF. DIVU 100/7 -> 14; REMU -> 2.
- DIVU SrcA=0x1234, SrcB=0 -> Done at T+1, Result=0xFFFFFFFF. Same operands with REMU -> 0x1234. DIV 0x80000000 / 0xFFFFFFFF -> Done at T+1, Result=0x80000000; REM -> 0.
- Kill at T+10 during DIV -> Busy=0 at T+11, no Done, Result holds previous value; a new Start at T+11 completes normally. Also: reset asserted at T+5 -> all outputs 0 immediately.
- Start held high while Busy -> exactly one Done per accept. With MULDIV_EARLY_OUT_EN, MULHU 5×3 -> Done at T+4, Result=0 (MUL low half 15). Without the macro -> Done at T+34.
